// File: rtl/ddr_pkg.sv
// ddr_pkg: shared state, width constants and latched-command type for the DDR3 arbiter
package ddr_pkg;
  localparam int DDR_ADDR_W = 25;
  localparam int DDR_DATA_W = 128;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} arb_state_t;
  typedef struct packed {
    logic [DDR_ADDR_W-1:0] address;
    logic [DDR_DATA_W-1:0] wdata;
    logic                  is_write;
  } ddr_cmd_t;
endpackage

// File: rtl/ddr_arbiter_if.sv
// ddr_arbiter_if: requester-side and DDR3 Avalon-side signals of the arbiter
interface ddr_arbiter_if import ddr_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DDR_ADDR_W,
  parameter int DATA_W  = DDR_DATA_W
) ();
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ack;
  logic [DATA_W-1:0]              req_rdata;
  logic [NUM_REQ-1:0]             req_rdatavalid;
  logic [NUM_REQ-1:0]             req_err;
  logic                           local_init_done;
  logic [ADDR_W-1:0]              avl_address;
  logic [DATA_W-1:0]              avl_writedata;
  logic                           avl_read;
  logic                           avl_write;
  logic                           avl_burstbegin;
  logic                           avl_wait_request_n;
  logic [DATA_W-1:0]              avl_readdata;
  logic                           avl_readdatavalid;
  modport master (
    input  req_read, req_write, req_address, req_wdata, local_init_done,
           avl_wait_request_n, avl_readdata, avl_readdatavalid,
    output req_ack, req_rdata, req_rdatavalid, req_err,
           avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin
  );
  modport slave (
    output req_read, req_write, req_address, req_wdata, local_init_done,
           avl_wait_request_n, avl_readdata, avl_readdatavalid,
    input  req_ack, req_rdata, req_rdatavalid, req_err,
           avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin
  );
endinterface

// File: rtl/ddr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first requester strictly after last wins
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = N; k > 0; k--) begin
      if (req[(int'(last) + k) % N]) begin
        idx = IW'((int'(last) + k) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin single-beat DDR3 Avalon arbiter; watchdog abort enabled by DDR_ARB_TIMEOUT_EN
module ddr_arbiter import ddr_pkg::*; #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = DDR_ADDR_W,
  parameter int DATA_W         = DDR_DATA_W,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic           iCLK,
  input logic           reset,
  ddr_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state, state_d;
  ddr_cmd_t cmd, cmd_d;
  logic [IW-1:0] grant, grant_d, last_grant, last_d, pick;
  logic pick_valid, rd, wr, rd_d, wr_d, start, accept, done_rd, abort, tmo;
  logic [NUM_REQ-1:0] ack, ack_d, err, err_d, g_onehot;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req_read | bus.req_write),
    .last  (last_grant),
    .idx   (pick),
    .valid (pick_valid)
  );
  assign g_onehot = NUM_REQ'(1) << grant;
  assign start = state == IDLE && bus.local_init_done && pick_valid && ~|ack;
  assign accept = state == ISSUE && bus.avl_wait_request_n;
  assign done_rd = state == WAIT_DATA && bus.avl_readdatavalid;
  assign abort = tmo && !accept && !done_rd;
`ifdef DDR_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = state != IDLE && cnt == 16'(TIMEOUT_CYCLES - 1);
  // watchdog: restarts on every state entry and rests at zero in IDLE
  always_ff @(posedge iCLK) cnt <= (reset || state == IDLE || state_d != state) ? '0 : cnt + 16'd1;
`else
  logic unused_timeout;
  assign tmo = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
  // state register plus registered command, grant and handshake outputs
  always_ff @(posedge iCLK) begin
    if (reset) begin
      state <= IDLE;
      cmd <= '0;
      grant <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      rd <= 1'b0;
      wr <= 1'b0;
      ack <= '0;
      err <= '0;
    end else begin
      state <= state_d;
      cmd <= cmd_d;
      grant <= grant_d;
      last_grant <= last_d;
      rd <= rd_d;
      wr <= wr_d;
      ack <= ack_d;
      err <= err_d;
    end
  end
  // next state: writes finish on acceptance, reads on the first data beat
  always_comb begin
    state_d = state == IDLE  ? (start ? ISSUE : IDLE)
            : state == ISSUE ? (accept ? (cmd.is_write ? IDLE : WAIT_DATA) : (abort ? IDLE : ISSUE))
            : (done_rd || abort) ? IDLE : WAIT_DATA;
  end
  // next values of the latched command and registered outputs; write wins over read
  always_comb begin
    cmd_d = cmd;
    if (start) begin
      cmd_d.address = DDR_ADDR_W'(bus.req_address[pick]);
      cmd_d.wdata = DDR_DATA_W'(bus.req_wdata[pick]);
      cmd_d.is_write = bus.req_write[pick];
    end
    grant_d = start ? pick : grant;
    rd_d = state_d == ISSUE && !cmd_d.is_write;
    wr_d = state_d == ISSUE && cmd_d.is_write;
    ack_d = accept ? g_onehot : '0;
    err_d = abort ? g_onehot : '0;
    last_d = (accept || abort) ? grant : last_grant;
  end
  assign bus.avl_address = cmd.address[ADDR_W-1:0];
  assign bus.avl_writedata = cmd.wdata[DATA_W-1:0];
  assign bus.avl_read = rd;
  assign bus.avl_write = wr;
  assign bus.avl_burstbegin = rd | wr;
  assign bus.req_ack = ack;
  assign bus.req_err = err;
  assign bus.req_rdata = bus.avl_readdata;
  assign bus.req_rdatavalid = done_rd ? g_onehot : '0;
endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: directed self-checking bench for ddr_arbiter
module tb_ddr_arbiter;
  import ddr_pkg::*;
  localparam logic [24:0]  A0  = 25'h00ABCDE;
  localparam logic [24:0]  A1  = 25'h0001234;
  localparam logic [127:0] WD0 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] WD1 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] RD0 = 128'h0badf00d_0badf00d_0badf00d_0badf00d;
  localparam logic [127:0] RD1 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  logic iCLK = 1'b0;
  logic reset = 1'b1;
  logic seen;
  int n_asserts = 0;
  int n_fail = 0;
  ddr_arbiter_if #(.NUM_REQ(2), .ADDR_W(25), .DATA_W(128)) bus ();
  ddr_arbiter #(.NUM_REQ(2), .ADDR_W(25), .DATA_W(128), .TIMEOUT_CYCLES(8)) dut (
    .iCLK  (iCLK),
    .reset (reset),
    .bus   (bus)
  );
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge iCLK);
  endtask
  initial begin
    bus.req_read = '0;
    bus.req_write = '0;
    bus.req_address[0] = A0;
    bus.req_address[1] = A1;
    bus.req_wdata[0] = WD0;
    bus.req_wdata[1] = WD1;
    bus.local_init_done = 1'b0;
    bus.avl_wait_request_n = 1'b0;
    bus.avl_readdata = '0;
    bus.avl_readdatavalid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_read", bus.avl_read, 0);
    chk("rst_write", bus.avl_write, 0);
    chk("rst_burst", bus.avl_burstbegin, 0);
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_err", bus.req_err, 0);
    chk("rst_addr", bus.avl_address, 0);
    chk("rst_wdata", bus.avl_writedata, 0);
    chk("rst_rdv", bus.req_rdatavalid, 0);
    chk("rst_state", dut.state, IDLE);
    // init gating
    bus.req_read = 2'b01;
    seen = 1'b0;
    repeat (20) begin
      tick;
      seen = seen | bus.avl_read;
    end
    chk("init_gate", seen, 0);
    bus.local_init_done = 1'b1;
    tick;
    chk("init_read", bus.avl_read, 1);
    chk("init_addr", bus.avl_address, A0);
    chk("init_burst", bus.avl_burstbegin, 1);
    chk("init_write", bus.avl_write, 0);
    bus.avl_wait_request_n = 1'b1;
    tick;
    chk("init_ack", bus.req_ack, 2'b01);
    chk("init_drop", bus.avl_read, 0);
    chk("init_wait", dut.state, WAIT_DATA);
    bus.req_read = '0;
    bus.avl_readdata = RD0;
    bus.avl_readdatavalid = 1'b1;
    #1;
    chk("init_rdv", bus.req_rdatavalid, 2'b01);
    chk("init_rdata", bus.req_rdata, RD0);
    tick;
    bus.avl_readdatavalid = 1'b0;
    chk("init_idle", dut.state, IDLE);
    chk("init_ack_pulse", bus.req_ack, 0);
    // round-robin fairness after reset: 0,1,0,1
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.req_write = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_write", bus.avl_write, 1);
      chk("rr_wdata", bus.avl_writedata, (i % 2) ? WD1 : WD0);
      chk("rr_addr", bus.avl_address, (i % 2) ? A1 : A0);
      tick;
      chk("rr_ack", bus.req_ack, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_drop", bus.avl_write, 0);
      if (i == 3) bus.req_write = '0;
      tick;
      chk("rr_ack_pulse", bus.req_ack, 0);
    end
    // wait-request stall on requester 1
    bus.req_read = 2'b10;
    bus.avl_wait_request_n = 1'b0;
    tick;
    for (int k = 0; k < 6; k++) begin
      chk("stall_read", bus.avl_read, 1);
      chk("stall_addr", bus.avl_address, A1);
      if (k == 5) bus.avl_wait_request_n = 1'b1;
      tick;
    end
    chk("stall_ack", bus.req_ack, 2'b10);
    chk("stall_drop", bus.avl_read, 0);
    bus.req_read = '0;
    repeat (3) begin
      tick;
      chk("stall_ack_once", bus.req_ack, 0);
      chk("stall_no_rdv", bus.req_rdatavalid, 0);
    end
    bus.avl_readdata = RD1;
    bus.avl_readdatavalid = 1'b1;
    #1;
    chk("stall_rdv", bus.req_rdatavalid, 2'b10);
    chk("stall_rdata", bus.req_rdata, RD1);
    tick;
    bus.avl_readdatavalid = 1'b0;
    chk("stall_idle", dut.state, IDLE);
    // simultaneous read+write on requester 0, then stray read data in IDLE
    bus.req_read = 2'b01;
    bus.req_write = 2'b01;
    tick;
    chk("rw_write", bus.avl_write, 1);
    chk("rw_noread", bus.avl_read, 0);
    chk("rw_wdata", bus.avl_writedata, WD0);
    tick;
    chk("rw_ack", bus.req_ack, 2'b01);
    bus.req_read = '0;
    bus.req_write = '0;
    bus.avl_readdatavalid = 1'b1;
    #1;
    chk("stray_rdv", bus.req_rdatavalid, 0);
    tick;
    bus.avl_readdatavalid = 1'b0;
    chk("stray_state", dut.state, IDLE);
    chk("stray_read", bus.avl_read, 0);
    chk("stray_write", bus.avl_write, 0);
    // reset in WAIT_DATA
    bus.req_read = 2'b10;
    tick;
    chk("mid_read", bus.avl_read, 1);
    chk("mid_addr", bus.avl_address, A1);
    tick;
    chk("mid_ack", bus.req_ack, 2'b10);
    chk("mid_wait", dut.state, WAIT_DATA);
    bus.req_read = '0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_read", bus.avl_read, 0);
    chk("mrst_ack", bus.req_ack, 0);
    chk("mrst_addr", bus.avl_address, 0);
    chk("mrst_wdata", bus.avl_writedata, 0);
    chk("mrst_state", dut.state, IDLE);
    bus.avl_readdatavalid = 1'b1;
    #1;
    chk("mrst_late_rdv", bus.req_rdatavalid, 0);
    bus.avl_readdatavalid = 1'b0;
    bus.req_read = 2'b11;
    tick;
    chk("mrst_next_read", bus.avl_read, 1);
    chk("mrst_next_addr", bus.avl_address, A0);
    tick;
    chk("mrst_next_ack", bus.req_ack, 2'b01);
    bus.req_read = 2'b10;
    bus.avl_readdata = RD1;
    bus.avl_readdatavalid = 1'b1;
    #1;
    chk("mrst_next_rdv", bus.req_rdatavalid, 2'b01);
    bus.req_read = '0;
    tick;
    bus.avl_readdatavalid = 1'b0;
    chk("mrst_err", bus.req_err, 0);
`ifdef DDR_ARB_TIMEOUT_EN
    // watchdog abort: no data ever returned for requester 1
    bus.req_read = 2'b10;
    tick;
    chk("tmo_read", bus.avl_read, 1);
    tick;
    chk("tmo_ack", bus.req_ack, 2'b10);
    bus.req_read = 2'b11;
    for (int k = 1; k < 8; k++) begin
      tick;
      chk("tmo_no_err", bus.req_err, 0);
    end
    tick;
    chk("tmo_err", bus.req_err, 2'b10);
    chk("tmo_idle", dut.state, IDLE);
    tick;
    chk("tmo_err_pulse", bus.req_err, 0);
    chk("tmo_next_read", bus.avl_read, 1);
    chk("tmo_next_addr", bus.avl_address, A0);
    bus.req_read = '0;
`endif
    reset = 1'b1;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
